serial_code_lock: RTL and testbench

Parametrised serial code-lock FSM for the safety-lock datapath. It accepts a CODE_LEN-bit code one bit per valid cycle, MSB first, and aborts early on the first mismatching bit. It issues a one-cycle pass/fail verdict per attempt. Consecutive failures are counted, and reaching MAX_FAIL enters a timed lockout during which all input is ignored.

---
 rtl/serial_code_lock.sv | 127 ++++++++++++
 tb/tb_serial_code_lock.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/serial_code_lock.sv
// Serial code lock: checks a CODE_LEN-bit code entered MSB first and issues one pass/fail strobe per attempt.
// Define CODE_LOCK_LOCKOUT_EN to enable the consecutive-fail counter and the timed lockout.
module serial_code_lock #(
   parameter int                  CODE_LEN       = 4,
   parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
   parameter int                  MAX_FAIL       = 3,
   parameter int                  LOCKOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic ser_valid,
   input  logic ser_data,
   output logic output_valid,
   output logic out,
   output logic locked
);

   localparam int IDX_W = $clog2(CODE_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_GAP, LOCKOUT} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic               vld_nxt, out_nxt;
   logic               bit_ok;
   logic [CODE_LEN-1:0] code_rev;

   // code_rev[i] is the bit expected at entry index i
   for (genvar i = 0; i < CODE_LEN; i++) begin : g_rev
      assign code_rev[i] = CODE[CODE_LEN-1-i];
   end

   assign bit_ok = (ser_data == code_rev[idx]);

`ifdef CODE_LOCK_LOCKOUT_EN
   localparam int FC_W = $clog2(MAX_FAIL + 1);
   localparam int LC_W = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [FC_W-1:0] MAX_FC   = FC_W'(MAX_FAIL);
   localparam logic [LC_W-1:0] LC_LOAD  = LC_W'(LOCKOUT_CYCLES - 1);

   logic [FC_W-1:0] fail_cnt, fail_nxt, fail_inc;
   logic [LC_W-1:0] lock_cnt, lock_nxt;

   assign fail_inc = (fail_cnt == MAX_FC) ? fail_cnt : fail_cnt + 1'b1;
   assign locked   = (state == LOCKOUT);
`else
   logic unused_cfg;
   assign unused_cfg = ^{32'(MAX_FAIL), 32'(LOCKOUT_CYCLES)};
   assign locked     = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      vld_nxt   = 1'b0;
      out_nxt   = 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
      fail_nxt  = fail_cnt;
      lock_nxt  = lock_cnt;
`endif
      case (state)
         IDLE, SHIFT: begin
            if (ser_valid) begin
               if (bit_ok && idx != LAST_IDX) begin
                  idx_nxt   = idx + 1'b1;
                  state_nxt = SHIFT;
               end else begin
                  vld_nxt   = 1'b1;
                  out_nxt   = bit_ok;
                  idx_nxt   = '0;
                  state_nxt = bit_ok ? IDLE : WAIT_GAP;
`ifdef CODE_LOCK_LOCKOUT_EN
                  if (bit_ok) begin
                     fail_nxt = '0;
                  end else begin
                     fail_nxt = fail_inc;
                     if (fail_inc == MAX_FC) begin
                        state_nxt = LOCKOUT;
                        lock_nxt  = LC_LOAD;
                     end
                  end
`endif
               end
            end
         end
         WAIT_GAP: begin
            // one idle edge is required to re-arm after a fail
            if (!ser_valid) state_nxt = IDLE;
         end
`ifdef CODE_LOCK_LOCKOUT_EN
         LOCKOUT: begin
            if (lock_cnt == '0) begin
               fail_nxt  = '0;
               state_nxt = WAIT_GAP;
            end else begin
               lock_nxt = lock_cnt - 1'b1;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= IDLE;
         idx          <= '0;
         output_valid <= 1'b0;
         out          <= 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
         fail_cnt     <= '0;
         lock_cnt     <= '0;
`endif
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         output_valid <= vld_nxt;
         out          <= out_nxt;
`ifdef CODE_LOCK_LOCKOUT_EN
         fail_cnt     <= fail_nxt;
         lock_cnt     <= lock_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_serial_code_lock.sv
// Directed bench for serial_code_lock: table of per-edge vectors plus lockout / unlimited-attempt sequences.
module tb_serial_code_lock;

   logic clk = 1'b0;
   logic rstn, ser_valid, ser_data;
   logic output_valid, out, locked;

   always #5 clk = ~clk;

   serial_code_lock dut (
      .clk          (clk),
      .rstn         (rstn),
      .ser_valid    (ser_valid),
      .ser_data     (ser_data),
      .output_valid (output_valid),
      .out          (out),
      .locked       (locked)
   );

   typedef struct {
      logic r, v, d;      // rstn, ser_valid, ser_data
      logic ev, eo, el;   // expected output_valid, out, locked after the edge
   } vec_t;

   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;
   logic [3:0] code = 4'b1011;

   task automatic add(input logic r, v, d, ev, eo, el);
      vec_t x;
      x = '{r, v, d, ev, eo, el};
      tbl.push_back(x);
   endtask

   task automatic step(input logic r, v, d, ev, eo, el, input string tag);
      @(negedge clk);
      rstn = r; ser_valid = v; ser_data = d;
      @(posedge clk);
      #1;
      total++;
      if ({output_valid, out, locked} !== {ev, eo, el}) begin
         bad++;
         $display("FAIL %s: vld/out/locked got %b%b%b want %b%b%b",
                  tag, output_valid, out, locked, ev, eo, el);
      end
   endtask

   // 1011 with pass verdict on the last edge
   task automatic add_pass();
      for (int i = 0; i < 4; i++) add(1, 1, code[3-i], (i == 3), (i == 3), 0);
   endtask

   task automatic add_fail0_gap();
      add(1, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rstn = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;

      // reset state
      add(0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0);
      // scenario 1: contiguous pass, then strobe drops
      add_pass();
      add(1, 0, 0, 0, 0, 0);
      // scenario 2: gaps inside the code
      add(1, 1, 1, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0);
      add(1, 1, 1, 1, 1, 0);
      // scenario 3: fail at bit 1, trailing bits discarded, gap, pass
      add(1, 1, 1, 0, 0, 0);
      add(1, 1, 1, 1, 0, 0);
      add(1, 1, 0, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0);
      add_pass();
      // back-to-back passes with no gap
      add_pass();
      add_pass();
      // scenario 5: reset mid-attempt
      add(1, 1, 1, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0);
      add_pass();
      // reset coincident with the deciding bit wins
      add(1, 1, 1, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0);
      add_pass();
      // fail at last bit; pass clears history so later fails do not lock
      add_fail0_gap();
      add(1, 1, 1, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0);
      add(1, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0);
      add_pass();
      add(1, 1, 1, 0, 0, 0);
      add(1, 1, 1, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0);
      add_fail0_gap();
      // reset clears the fail history
      add(0, 0, 0, 0, 0, 0);
      add_fail0_gap();
      add_fail0_gap();
      add(0, 0, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].ev, tbl[i].eo, tbl[i].el,
              $sformatf("vec%0d", i));

`ifdef CODE_LOCK_LOCKOUT_EN
      // scenario 4: third fail locks, 16 locked cycles ignore input
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 0, 1, 0, (k == 2), $sformatf("lock_fail%0d", k));
         if (k < 2) step(1, 0, 0, 0, 0, 0, "lock_gap");
      end
      for (int k = 1; k <= 16; k++)
         step(1, 1, code[3-((k-1)%4)], 0, 0, (k < 16), $sformatf("lock_hold%0d", k));
      step(1, 0, 0, 0, 0, 0, "lock_regap");
      for (int i = 0; i < 4; i++)
         step(1, 1, code[3-i], (i == 3), (i == 3), 0, "lock_pass");
`else
      // scenario 6: unlimited attempts, never locked
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 0, 1, 0, 0, $sformatf("nolock_fail%0d", k));
         step(1, 0, 0, 0, 0, 0, "nolock_gap");
      end
      for (int i = 0; i < 4; i++)
         step(1, 1, code[3-i], (i == 3), (i == 3), 0, "nolock_pass");
`endif
      step(1, 0, 0, 0, 0, 0, "final_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
